// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: types and helpers shared by the serial adder and its slice.
//   state_t   : FSM encoding (IDLE, RUN, DONE)
//   cnt_width : width of the chunk counter for N chunks (minimum 1 bit)
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// adder_slice: combinational CHUNK-bit ripple-carry adder.
// Ports:
//   i_a, i_b : CHUNK-bit addends
//   i_cin    : carry into bit 0
//   o_sum    : CHUNK-bit sum
//   o_cout   : carry out of the top bit
module adder_slice #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout
);

  logic w_c;

  // Bit-serial ripple; w_c carries from bit i into bit i+1.
  always_comb begin
    o_sum  = '0;
    o_cout = 1'b0;
    w_c    = i_cin;
    for (int i = 0; i < int'(CHUNK); i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c;
  end

endmodule

// File: rtl/serial_adder.sv
// serial_adder: WIDTH-bit adder that processes CHUNK bits per clock,
// LSB chunk first, through a single adder_slice.
// Optional feature: define SERIAL_ADDER_SUB_EN to add the 'sub' input
// (a - b computed as a + ~b + 1; cout=1 means no borrow).
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   start : request an add, accepted only while ready=1
//   a, b  : WIDTH-bit operands, sampled on the accepting edge
//   cin   : carry-in, sampled on the accepting edge
//   sub   : (SERIAL_ADDER_SUB_EN only) subtract, sampled with a
//   ready : high in IDLE
//   busy  : high in RUN
//   done  : one-cycle result-valid pulse
//   sum   : WIDTH-bit result, held until the next done
//   cout  : final carry-out, held with sum
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned CNT_W = cnt_width(N);
  localparam int unsigned IDX_W = $clog2(WIDTH) + 1;

  if ((N == 0) || (N * CHUNK != WIDTH)) begin : g_bad_cfg
    $error("serial_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_psum;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;

  logic               w_accept;
  logic               w_last;
  logic [IDX_W-1:0]   w_base;
  logic [CHUNK-1:0]   w_chunk_sum;
  logic               w_chunk_cout;
  logic [WIDTH-1:0]   w_psum_next;
  logic [WIDTH-1:0]   w_b_in;
  logic               w_carry_in;
  logic               w_ready;
  logic               w_busy;
  logic               w_done;

  assign w_accept = start && (r_state == IDLE);
  assign w_last   = (r_cnt == CNT_W'(N - 1));
  assign w_base   = IDX_W'(r_cnt) * IDX_W'(CHUNK);

  // Operand conditioning at accept: subtraction is a + ~b with carry-in forced to 1.
`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_in     = sub ? ~b : b;
  assign w_carry_in = sub ? 1'b1 : cin;
`else
  assign w_b_in     = b;
  assign w_carry_in = cin;
`endif

  adder_slice #(
    .CHUNK (CHUNK)
  ) u_slice (
    .i_a    (r_a[w_base +: CHUNK]),
    .i_b    (r_b[w_base +: CHUNK]),
    .i_cin  (r_carry),
    .o_sum  (w_chunk_sum),
    .o_cout (w_chunk_cout)
  );

  // Partial sum with the current chunk merged in; on the last chunk this is the full result.
  always_comb begin
    w_psum_next                   = r_psum;
    w_psum_next[w_base +: CHUNK]  = w_chunk_sum;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output decode from the state register.
  always_comb begin
    w_ready = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      IDLE:    w_ready = 1'b1;
      RUN:     w_busy  = 1'b1;
      DONE:    w_done  = 1'b1;
      default: w_ready = 1'b0;
    endcase
  end

  // Datapath: capture on accept, one chunk per RUN edge, publish result on the last chunk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_psum  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= w_b_in;
      r_carry <= w_carry_in;
      r_cnt   <= '0;
      r_psum  <= '0;
    end else if (r_state == RUN) begin
      r_psum  <= w_psum_next;
      r_carry <= w_chunk_cout;
      r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
      if (w_last) begin
        r_sum  <= w_psum_next;
        r_cout <= w_chunk_cout;
      end
    end
  end

  assign ready = w_ready;
  assign busy  = w_busy;
  assign done  = w_done;
  assign sum   = r_sum;
  assign cout  = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder against an
// arithmetic reference, for WIDTH=16/CHUNK=4 and WIDTH=8/CHUNK=8.
module tb_serial_adder;

  localparam int unsigned W  = 16;
  localparam int unsigned C  = 4;
  localparam int unsigned N  = W / C;
  localparam int unsigned W8 = 8;
  localparam int unsigned N8 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start, cin, ready, busy, done, cout;
  logic [W-1:0]  a, b, sum;
  logic          start8, cin8, ready8, busy8, done8, cout8;
  logic [W8-1:0] a8, b8, sum8;
`ifdef SERIAL_ADDER_SUB_EN
  logic          sub, sub8;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  serial_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_adder #(.WIDTH(W8), .CHUNK(W8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub8),
`endif
    .ready (ready8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  // Reference: {cout, sum} of the full-precision result.
  function automatic logic [W:0] ref16(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci, input logic s);
    if (s) return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    return {1'b0, x} + {1'b0, y} + (W+1)'(ci);
  endfunction

  function automatic logic [W8:0] ref8(input logic [W8-1:0] x, input logic [W8-1:0] y,
                                       input logic ci, input logic s);
    if (s) return {1'b0, x} + {1'b0, ~y} + (W8+1)'(1);
    return {1'b0, x} + {1'b0, y} + (W8+1)'(ci);
  endfunction

  task automatic check(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s.%s: observed 0x%0h expected 0x%0h", tag, what, obs, exp);
    end
  endtask

  // One 16-bit operation: accept, wait for done (bounded), check latency and result.
  task automatic do_op16(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tci, input logic ts, input string tag);
    logic [W:0] exp;
    int lat;
    exp = ref16(ta, tb, tci, ts);
    @(negedge clk);
    a = ta; b = tb; cin = tci; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub = ts;
`endif
    check(tag, "ready", 32'(ready), 32'(1));
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'($urandom);
`endif
    check(tag, "busy", 32'(busy), 32'(1));
    lat = 1;
    while (done !== 1'b1 && lat < int'(4 * N + 10)) begin
      @(negedge clk);
      lat++;
    end
    check(tag, "latency", 32'(lat), 32'(N + 1));
    check(tag, "done", 32'(done), 32'(1));
    check(tag, "sum", 32'(sum), 32'(exp[W-1:0]));
    check(tag, "cout", 32'(cout), 32'(exp[W]));
    @(negedge clk);
    check(tag, "done_pulse", 32'(done), 32'(0));
    check(tag, "ready_after", 32'(ready), 32'(1));
  endtask

  task automatic do_op8(input logic [W8-1:0] ta, input logic [W8-1:0] tb,
                        input logic tci, input logic ts, input string tag);
    logic [W8:0] exp;
    int lat;
    exp = ref8(ta, tb, tci, ts);
    @(negedge clk);
    a8 = ta; b8 = tb; cin8 = tci; start8 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = ts;
`endif
    @(negedge clk);
    start8 = 1'b0;
    a8 = W8'($urandom); b8 = W8'($urandom); cin8 = 1'($urandom);
    check(tag, "busy", 32'(busy8), 32'(1));
    lat = 1;
    while (done8 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check(tag, "latency", 32'(lat), 32'(N8 + 1));
    check(tag, "sum", 32'(sum8), 32'(exp[W8-1:0]));
    check(tag, "cout", 32'(cout8), 32'(exp[W8]));
    @(negedge clk);
    check(tag, "ready_after", 32'(ready8), 32'(1));
  endtask

  initial begin : main
    int lat;
    int cyc;
    int nd;
    int next_done;
    logic [W:0] exp;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0; sub8 = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset", "ready", 32'(ready), 32'(1));
    check("reset", "busy", 32'(busy), 32'(0));
    check("reset", "done", 32'(done), 32'(0));
    check("reset", "sum", 32'(sum), 32'(0));
    check("reset", "cout", 32'(cout), 32'(0));
    check("reset8", "ready", 32'(ready8), 32'(1));
    rst = 1'b0;

    // Directed cases.
    do_op16(16'h1234, 16'h4321, 1'b0, 1'b0, "add_5555");
    do_op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, "ripple_all");
    do_op16(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "max_cin");
    do_op16(16'h0000, 16'h0000, 1'b1, 1'b0, "cin_only");

    // Start during RUN and during DONE must be ignored.
    @(negedge clk);
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; start = 1'b1;
    check("ovl", "busy", 32'(busy), 32'(1));
    @(negedge clk);
    start = 1'b0;
    lat = 3;
    while (done !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("ovl", "latency", 32'(lat), 32'(N + 1));
    check("ovl", "sum", 32'(sum), 32'(16'h0100));
    check("ovl", "cout", 32'(cout), 32'(0));
    a = 16'h0002; b = 16'h0002; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ovl", "ready_after_done", 32'(ready), 32'(1));
    nd = 0;
    repeat (2 * N + 4) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    check("ovl", "extra_done", 32'(nd), 32'(0));
    check("ovl", "sum_held", 32'(sum), 32'(16'h0100));

    // Reset in the middle of RUN aborts without a done pulse.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst", "ready_async", 32'(ready), 32'(1));
    check("midrst", "sum_async", 32'(sum), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    check("midrst", "ready", 32'(ready), 32'(1));
    check("midrst", "busy", 32'(busy), 32'(0));
    check("midrst", "cout", 32'(cout), 32'(0));
    nd = 0;
    repeat (2 * N + 4) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    check("midrst", "no_done", 32'(nd), 32'(0));
    do_op16(16'hABCD, 16'h1234, 1'b1, 1'b0, "after_rst");

    // Start held high: one result every N+2 cycles.
    exp = ref16(16'h0F0F, 16'h1111, 1'b1, 1'b0);
    @(negedge clk);
    a = 16'h0F0F; b = 16'h1111; cin = 1'b1; start = 1'b1;
    cyc = 0; nd = 0; next_done = N + 1;
    repeat (3 * (N + 2) + 2) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        nd++;
        check("b2b", "done_cycle", 32'(cyc), 32'(next_done));
        check("b2b", "sum", 32'(sum), 32'(exp[W-1:0]));
        next_done += N + 2;
      end
    end
    check("b2b", "count", 32'(nd), 32'(3));
    start = 1'b0;
    repeat (2 * N + 4) @(negedge clk);

    // Random operands with random idle gaps.
    for (int i = 0; i < 40; i++) begin
      do_op16(W'($urandom), W'($urandom), 1'($urandom), 1'b0, "rand");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

`ifdef SERIAL_ADDER_SUB_EN
    do_op16(16'h0005, 16'h0007, 1'b0, 1'b1, "sub_borrow");
    do_op16(16'h0007, 16'h0005, 1'b0, 1'b1, "sub_noborrow");
    do_op16(16'h0007, 16'h0005, 1'b1, 1'b1, "sub_cin_ign");
    for (int i = 0; i < 10; i++)
      do_op16(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), "rand_sub");
`endif

    // Single-chunk instance.
    do_op8(8'h80, 8'h80, 1'b1, 1'b0, "n1_8080");
    for (int i = 0; i < 10; i++)
      do_op8(W8'($urandom), W8'($urandom), 1'($urandom), 1'b0, "n1_rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
